// File: rtl/pixel_write_queue.sv
// pixel_write_queue: range-checks drawer pixels, linearises their address and buffers them in a show-ahead FIFO,
// pulsing oFrameFlushed once every pixel of a finished frame has been written to video memory.
module pixel_write_queue #(
  parameter int X_SCREEN_PIXELS = 160,
  parameter int Y_SCREEN_PIXELS = 120,
  parameter int DEPTH = 8,
  parameter int ADDR_WIDTH = 15
) (
  input  logic                  iClock,
  input  logic                  iResetn,
  input  logic [7:0]            iX,
  input  logic [6:0]            iY,
  input  logic [2:0]            iColour,
  input  logic                  iPlot,
  input  logic                  iFrameDone,
  input  logic                  iMemReady,
  output logic [ADDR_WIDTH-1:0] oMemAddr,
  output logic [2:0]            oMemData,
  output logic                  oMemWe,
  output logic                  oFull,
  output logic                  oOverflow,
  output logic [7:0]            oDropped,
  output logic                  oFrameFlushed
);
  localparam int PW = $clog2(DEPTH);
  localparam int EW = ADDR_WIDTH + 3;
  typedef enum logic [1:0] {IDLE, FLUSH, DONE} state_t;
  state_t state, state_next;
  logic [EW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0] count, count_next;
  logic in_range, push, pop;
  logic [ADDR_WIDTH-1:0] addr;
  assign in_range = 32'(iX) < X_SCREEN_PIXELS && 32'(iY) < Y_SCREEN_PIXELS;
  assign addr = ADDR_WIDTH'(iY) * ADDR_WIDTH'(X_SCREEN_PIXELS) + ADDR_WIDTH'(iX);
  assign oFull = count == (PW+1)'(DEPTH);
  assign oMemWe = count != '0;
  assign push = iPlot && in_range && !oFull;
  assign pop = oMemWe && iMemReady;
  assign count_next = count + (PW+1)'(push) - (PW+1)'(pop);
  // Outputs are forced to zero while empty so stale storage never shows after reset.
  assign oMemAddr = oMemWe ? mem[rd_ptr][EW-1:3] : '0;
  assign oMemData = oMemWe ? mem[rd_ptr][2:0] : '0;
  assign oFrameFlushed = state == DONE;
  always_ff @(posedge iClock)
    if (push) mem[wr_ptr] <= {addr, iColour};
  always_ff @(posedge iClock or negedge iResetn)
    if (!iResetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      oOverflow <= 1'b0;
      oDropped <= '0;
      state <= IDLE;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
      if (iPlot && in_range && oFull) oOverflow <= 1'b1;
      if (iPlot && !in_range && oDropped != 8'hff) oDropped <= oDropped + 8'd1;
      state <= state_next;
    end
  // Flush completes on the edge that empties the queue, so the pulse lands the cycle after the last pop.
  always_comb begin
    state_next = state == IDLE  ? (iFrameDone ? FLUSH : IDLE) :
                 state == FLUSH ? (count_next == '0 ? DONE : FLUSH) :
                                  (iFrameDone ? FLUSH : IDLE);
  end
endmodule
